// File: rtl/mipi_csi_rx_lane_sync_ctrl.sv
// Purpose: sequences the CSI-2 lane aligner: re-arms it, enforces skew and sync windows, reports packets and errors.
// Latency: every output is registered; decisions on the inputs sampled at edge N appear after edge N.
// Backpressure: none; the block only observes flags and cannot stall the byte stream. Drains until all lanes go idle.
//
// Ports:
//   clk_i            byte clock
//   reset_n_i        asynchronous active-low reset
//   bytes_valid_i    per-lane byte-valid flags from the byte aligners
//   lane_valid_i     lane aligner sync output
//   aligner_reset_o  active-high re-arm pulse to the lane aligner
//   packet_active_o  high while an aligned packet is in flight
//   lane_skew_o      first-to-last lane skew of the most recent packet
//   skew_err_o       pulse: skew window exceeded or a lane dropped before all were valid
//   sync_err_o       pulse: sync timeout, lane drop while waiting for sync, or sync lost mid-packet
//   err_count_o      saturating error-event count
//   state_o          current state encoding (debug)
`timescale 1ns/1ps
module mipi_csi_rx_lane_sync_ctrl #(
   parameter int MIPI_LANES    = 2,
   parameter int MAX_SKEW      = 7,
   parameter int SYNC_TIMEOUT  = 15,
   parameter int RESET_CYCLES  = 2,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [MIPI_LANES-1:0]           bytes_valid_i,
   input  logic                            lane_valid_i,
   output logic                            aligner_reset_o,
   output logic                            packet_active_o,
   output logic [$clog2(MAX_SKEW+1)-1:0]   lane_skew_o,
   output logic                            skew_err_o,
   output logic                            sync_err_o,
   output logic [ERR_CNT_WIDTH-1:0]        err_count_o,
   output logic [2:0]                      state_o
);

   localparam int SKEW_W  = $clog2(MAX_SKEW+1);
   // One shared counter serves the re-arm, skew and sync-timeout phases,
   // so it must hold the largest terminal value of the three.
   localparam int CNT_MAX = (MAX_SKEW > SYNC_TIMEOUT) ?
                            ((MAX_SKEW > RESET_CYCLES) ? MAX_SKEW : RESET_CYCLES) :
                            ((SYNC_TIMEOUT > RESET_CYCLES) ? SYNC_TIMEOUT : RESET_CYCLES);
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX+1);

   typedef enum logic [2:0] {
      S_RECOVER   = 3'd0,
      S_IDLE      = 3'd1,
      S_WAIT_ALL  = 3'd2,
      S_WAIT_SYNC = 3'd3,
      S_ACTIVE    = 3'd4,
      S_DRAIN     = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [MIPI_LANES-1:0]   bv_q;
   logic                    all_valid, any_valid, lane_dropped;
   logic                    ev_skew_err, ev_sync_err, ev_skew_ld;
   logic [SKEW_W-1:0]       skew_ld_val;
   logic                    aligner_reset_d, packet_active_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

   assign all_valid    = &bytes_valid_i;
   assign any_valid    = |bytes_valid_i;
   // A lane that was valid last cycle and is not now.
   assign lane_dropped = |(bv_q & ~bytes_valid_i);

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_RECOVER;
         cnt_q   <= '0;
         bv_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bv_q    <= bytes_valid_i;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ev_skew_err = 1'b0;
      ev_sync_err = 1'b0;
      ev_skew_ld  = 1'b0;
      skew_ld_val = '0;
      case (state_q)
         S_RECOVER: begin
            if (cnt_q == CNT_W'(RESET_CYCLES-1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IDLE: begin
            if (all_valid) begin
               state_d    = S_WAIT_SYNC;
               cnt_d      = '0;
               ev_skew_ld = 1'b1;
            end else if (any_valid) begin
               state_d = S_WAIT_ALL;
               cnt_d   = CNT_W'(1);
            end
         end
         S_WAIT_ALL: begin
            // All-valid is tested first so it wins over the skew limit.
            if (all_valid) begin
               state_d     = S_WAIT_SYNC;
               cnt_d       = '0;
               ev_skew_ld  = 1'b1;
               skew_ld_val = cnt_q[SKEW_W-1:0];
            end else if (lane_dropped || (cnt_q == CNT_W'(MAX_SKEW))) begin
               state_d     = S_DRAIN;
               ev_skew_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_SYNC: begin
            if (lane_valid_i) begin
               state_d = S_ACTIVE;
            end else if (!all_valid || (cnt_q == CNT_W'(SYNC_TIMEOUT))) begin
               state_d     = S_DRAIN;
               ev_sync_err = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACTIVE: begin
            // A byte lane falling is a normal end even if sync drops with it.
            if (!all_valid) begin
               state_d = S_DRAIN;
            end else if (!lane_valid_i) begin
               state_d     = S_DRAIN;
               ev_sync_err = 1'b1;
            end
         end
         S_DRAIN: begin
            if (!any_valid) begin
               state_d = S_RECOVER;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_RECOVER;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: next values of the registered level outputs
   always_comb begin
      aligner_reset_d = (state_d == S_RECOVER);
      packet_active_d = (state_d == S_ACTIVE);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         aligner_reset_o <= 1'b1;
         packet_active_o <= 1'b0;
         lane_skew_o     <= '0;
         skew_err_o      <= 1'b0;
         sync_err_o      <= 1'b0;
         err_cnt_q       <= '0;
      end else begin
         aligner_reset_o <= aligner_reset_d;
         packet_active_o <= packet_active_d;
         skew_err_o      <= ev_skew_err;
         sync_err_o      <= ev_sync_err;
         if (ev_skew_ld) begin
            lane_skew_o <= skew_ld_val;
         end
         // The two error events are mutually exclusive by construction.
         if ((ev_skew_err || ev_sync_err) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
         end
      end
   end

   assign err_count_o = err_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_mipi_csi_rx_lane_sync_ctrl.sv
`timescale 1ns/1ps
module tb_mipi_csi_rx_lane_sync_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  bv;
   logic        lv;

   logic        ar, pa, se, ye;
   logic [2:0]  skew, st;
   logic [15:0] ec;

   logic        ar2, pa2, se2, ye2;
   logic [2:0]  skew2, st2;
   logic [1:0]  ec2;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   mipi_csi_rx_lane_sync_ctrl dut (
      .clk_i(clk), .reset_n_i(rst_n), .bytes_valid_i(bv), .lane_valid_i(lv),
      .aligner_reset_o(ar), .packet_active_o(pa), .lane_skew_o(skew),
      .skew_err_o(se), .sync_err_o(ye), .err_count_o(ec), .state_o(st)
   );

   // Narrow error counter instance to reach saturation in a few events.
   mipi_csi_rx_lane_sync_ctrl #(.ERR_CNT_WIDTH(2)) dut_sat (
      .clk_i(clk), .reset_n_i(rst_n), .bytes_valid_i(bv), .lane_valid_i(lv),
      .aligner_reset_o(ar2), .packet_active_o(pa2), .lane_skew_o(skew2),
      .skew_err_o(se2), .sync_err_o(ye2), .err_count_o(ec2), .state_o(st2)
   );

   // kind: 0 skew err (val=cycle), 1 sync err (val=cycle),
   //       2 packet done (val=length), 3 re-arm done (val=length)
   typedef struct {
      int kind;
      int val;
      int skw;
      int errc;
   } ev_t;

   ev_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input int kind, input int val, input int skw, input int errc);
      ev_t e;
      e.kind = kind; e.val = val; e.skw = skw; e.errc = errc;
      exp_q.push_back(e);
   endtask

   task automatic report(input int kind, input int val, input int skw);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: kind=%0d val=%0d, none expected", kind, val);
         return;
      end
      e = exp_q.pop_front();
      chk($sformatf("ev_kind(exp kind %0d)", e.kind), kind, e.kind);
      chk($sformatf("ev_val(kind %0d)", e.kind), val, e.val);
      chk($sformatf("ev_errc(kind %0d)", e.kind), int'(ec), e.errc);
      if (kind == 2) chk("ev_skew", skw, e.skw);
   endtask

   // Monitor: turns output activity into events and checks them against the queue.
   int   ar_run, pa_run;
   logic ar_prev, pa_prev;
   always @(negedge clk) begin
      if (!rst_n) begin
         ar_run  = 0;
         pa_run  = 0;
         ar_prev = 1'b1;
         pa_prev = 1'b0;
      end else begin
         if (se) report(0, cycle, 0);
         if (ye) report(1, cycle, 0);
         if (pa_prev && !pa) report(2, pa_run, int'(skew));
         if (ar_prev && !ar) report(3, ar_run, 0);
         ar_run  = ar ? ar_run + 1 : 0;
         pa_run  = pa ? pa_run + 1 : 0;
         ar_prev = ar;
         pa_prev = pa;
      end
   end

   // Inputs applied 1 ns after an edge; first sampled at the next edge.
   task automatic drive(input logic [1:0] b, input logic l, input int n);
      bv = b;
      lv = l;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_aligner_reset"}, int'(ar), 1);
      chk({tag, "_packet_active"}, int'(pa), 0);
      chk({tag, "_lane_skew"},     int'(skew), 0);
      chk({tag, "_skew_err"},      int'(se), 0);
      chk({tag, "_sync_err"},      int'(ye), 0);
      chk({tag, "_err_count"},     int'(ec), 0);
      chk({tag, "_state"},         int'(st), 0);
   endtask

   int t0;

   initial begin
      rst_n = 1'b0;
      bv    = 2'b00;
      lv    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");

      // Reset release: 2-cycle re-arm, then IDLE.
      expect_ev(3, 2, 0, 0);
      rst_n = 1'b1;
      drive(2'b00, 1'b0, 4);
      chk("post_reset_state", int'(st), 1);
      chk("post_reset_aligner_reset", int'(ar), 0);

      // Skew-1 packet, 6 active cycles.
      expect_ev(2, 6, 1, 0);
      expect_ev(3, 2, 0, 0);
      drive(2'b01, 1'b0, 1);
      drive(2'b11, 1'b0, 2);
      drive(2'b11, 1'b1, 6);
      drive(2'b00, 1'b0, 6);
      chk("pkt1_lane_skew", int'(skew), 1);
      chk("pkt1_err_count", int'(ec), 0);
      chk("pkt1_state", int'(st), 1);

      // Lanes aligned, sync after one cycle, 4 active cycles.
      expect_ev(2, 4, 0, 0);
      expect_ev(3, 2, 0, 0);
      drive(2'b11, 1'b0, 1);
      drive(2'b11, 1'b1, 4);
      drive(2'b00, 1'b0, 6);
      chk("pkt2_lane_skew", int'(skew), 0);

      // Lane1 alone: skew limit reached, then drain until it drops.
      t0 = cycle;
      expect_ev(0, t0 + 8, 0, 1);
      expect_ev(3, 2, 0, 1);
      drive(2'b10, 1'b0, 10);
      chk("skew_lim_drain_state", int'(st), 5);
      drive(2'b00, 1'b0, 6);
      chk("skew_lim_err_count", int'(ec), 1);
      chk("skew_lim_state", int'(st), 1);

      // All lanes valid, no sync: timeout.
      t0 = cycle;
      expect_ev(1, t0 + 17, 0, 2);
      expect_ev(3, 2, 0, 2);
      drive(2'b11, 1'b0, 20);
      drive(2'b00, 1'b0, 6);
      chk("timeout_err_count", int'(ec), 2);
      chk("sat_err_count_2", int'(ec2), 2);

      // Lane drops in WAIT_ALL.
      t0 = cycle;
      expect_ev(0, t0 + 2, 0, 3);
      expect_ev(3, 2, 0, 3);
      drive(2'b01, 1'b0, 1);
      drive(2'b00, 1'b0, 6);
      chk("sat_err_count_3", int'(ec2), 3);

      // Sync lost mid-packet while both lanes stay valid.
      t0 = cycle;
      expect_ev(1, t0 + 5, 0, 4);
      expect_ev(2, 3, 0, 4);
      expect_ev(3, 2, 0, 4);
      drive(2'b11, 1'b0, 1);
      drive(2'b11, 1'b1, 3);
      drive(2'b11, 1'b0, 2);
      drive(2'b00, 1'b0, 6);
      chk("sat_err_count_held4", int'(ec2), 3);

      // Lane drops while waiting for sync.
      t0 = cycle;
      expect_ev(1, t0 + 2, 0, 5);
      expect_ev(3, 2, 0, 5);
      drive(2'b11, 1'b0, 1);
      drive(2'b10, 1'b0, 1);
      drive(2'b00, 1'b0, 6);
      chk("sync_drop_err_count", int'(ec), 5);
      chk("sat_err_count_held5", int'(ec2), 3);

      // Asynchronous reset in the middle of an active packet.
      drive(2'b01, 1'b0, 1);
      drive(2'b11, 1'b0, 1);
      drive(2'b11, 1'b1, 3);
      chk("pre_abort_packet_active", int'(pa), 1);
      chk("pre_abort_lane_skew", int'(skew), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      chk("abort_sat_err_count", int'(ec2), 0);
      bv = 2'b00;
      lv = 1'b0;
      @(posedge clk);
      #1;
      expect_ev(3, 2, 0, 0);
      rst_n = 1'b1;
      drive(2'b00, 1'b0, 4);

      // Counting restarts from zero after the abort.
      t0 = cycle;
      expect_ev(0, t0 + 2, 0, 1);
      expect_ev(3, 2, 0, 1);
      drive(2'b01, 1'b0, 1);
      drive(2'b00, 1'b0, 6);
      chk("post_abort_err_count", int'(ec), 1);
      chk("post_abort_sat_err_count", int'(ec2), 1);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      while (exp_q.size() != 0) begin
         ev_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_event: kind=%0d val=%0d never observed", e.kind, e.val);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
